fifo_burst_reader: RTL and testbench

- Read-side controller for the team's show-ahead FIFO. In that FIFO, the head entry is always visible on its data output, and a pop takes effect when rden is high and empty is low.
- On a start command it pops exactly len entries and delivers them one by one to a downstream valid/ready consumer, such as the MAC feed. It then pulses done.
- Sits between a FIFO instance and its consumer. It is the other end of the FIFO's rden/empty/o_data interface.

---
 rtl/fifo_rd_pkg.sv | 13 +
 rtl/fifo_burst_reader.sv | 113 +++++++++++
 tb/tb_fifo_burst_reader.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_rd_pkg.sv
// Shared types for the FIFO burst read controller.
package fifo_rd_pkg;

  // Default largest burst a single start may request.
  localparam int MAX_LEN_DEF = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DRAIN    = 2'd1,
    WAIT_ACK = 2'd2
  } rd_state_e;

endpackage

// File: rtl/fifo_burst_reader.sv
// Pops a latched number of entries from a show-ahead FIFO and presents them
// one at a time on a registered valid/ready port, then pulses done.
module fifo_burst_reader
  import fifo_rd_pkg::*;
#(
  parameter int   DATA_WIDTH = 8,
  parameter int   MAX_LEN    = MAX_LEN_DEF,
  localparam int  LEN_W      = $clog2(MAX_LEN + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [LEN_W-1:0]      len,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic [LEN_W-1:0]      remaining,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_rden,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready
);

  localparam logic [LEN_W-1:0] MAX_LEN_W = LEN_W'(MAX_LEN);

  rd_state_e             state_q, state_d;
  logic [LEN_W-1:0]      remaining_q, remaining_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  done_q, done_d;
  logic                  pop;

  // Pop only when the output slot is free or being drained this cycle;
  // reset and abort both suppress the pop so no entry is consumed and lost.
  always_comb begin
    pop = (state_q == DRAIN) && !rst && !abort && !fifo_empty &&
          (remaining_q != '0) && (!out_valid_q || out_ready);
  end

  // Next-state, counter and output-register update.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (len == '0) begin
            done_d = 1'b1;
          end else begin
            remaining_d = (len > MAX_LEN_W) ? MAX_LEN_W : len;
            state_d     = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (pop) begin
          out_data_d  = fifo_data;
          out_valid_d = 1'b1;
          remaining_d = remaining_q - 1'b1;
          if (remaining_q == LEN_W'(1)) state_d = WAIT_ACK;
        end else if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
        end
      end
      WAIT_ACK: begin
        // The last beat is always pending here.
        if (out_ready) begin
          out_valid_d = 1'b0;
          done_d      = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Cancel drops the pending beat and the count without signalling done.
    if (abort && state_q != IDLE) begin
      state_d     = IDLE;
      out_valid_d = 1'b0;
      remaining_d = '0;
      done_d      = 1'b0;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      done_q      <= done_d;
    end
  end

  assign fifo_rden = pop;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign remaining = remaining_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: a small show-ahead FIFO model feeds the DUT,
// delivered beats are compared against a queue of expected data.
module tb_fifo_burst_reader;

  localparam int DW    = 8;
  localparam int LEN_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [LEN_W-1:0] len;
  logic             abort;
  logic             busy, done, fifo_rden, out_valid;
  logic [LEN_W-1:0] remaining;
  logic             fifo_empty;
  logic [DW-1:0]    fifo_data, out_data;
  logic             out_ready;

  // FIFO model (DEPTH=8), written by the bench through wr_en/wr_data.
  logic          fifo_clr, wr_en;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] fmem [8];
  logic [2:0]    frp, fwp;
  logic [3:0]    fcnt;
  logic          f_pop, f_push;
  int            pop_cnt;

  int n_chk = 0;
  int n_err = 0;
  logic [DW-1:0] exp_q[$];

  always #5 clk = ~clk;

  fifo_burst_reader #(.DATA_WIDTH(DW), .MAX_LEN(8)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .abort(abort),
    .busy(busy), .done(done), .remaining(remaining),
    .fifo_empty(fifo_empty), .fifo_data(fifo_data), .fifo_rden(fifo_rden),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready)
  );

  assign fifo_empty = (fcnt == 4'd0);
  assign fifo_data  = fmem[frp];
  assign f_pop      = fifo_rden && (fcnt != 4'd0);
  assign f_push     = wr_en && ((fcnt != 4'd8) || f_pop);

  always @(posedge clk) begin
    if (fifo_clr) begin
      frp <= '0; fwp <= '0; fcnt <= '0; pop_cnt <= 0;
    end else begin
      if (f_push) begin fmem[fwp] <= wr_data; fwp <= fwp + 3'd1; end
      if (f_pop) begin frp <= frp + 3'd1; pop_cnt <= pop_cnt + 1; end
      fcnt <= fcnt + 4'(f_push) - 4'(f_pop);
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  // Scoreboard: every accepted beat must match the next expected entry.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("beat_extra", 32'(out_data), 32'hFFFF_FFFF);
      else chk("beat", 32'(out_data), 32'(exp_q.pop_front()));
    end
    if (fifo_rden && fifo_empty) chk("rden_on_empty", 1, 0);
  end

  // Inputs change 1 time unit after the rising edge; checks at the falling edge.
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic fifo_flush();
    tick(); fifo_clr = 1'b1;
    tick(); fifo_clr = 1'b0;
  endtask

  task automatic load(input logic [DW-1:0] v [], input int n_exp);
    foreach (v[i]) begin
      tick(); wr_en = 1'b1; wr_data = v[i];
      if (i < n_exp) exp_q.push_back(v[i]);
    end
    tick(); wr_en = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int dcnt;
    logic [DW-1:0] v4 [] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [DW-1:0] v3 [] = '{8'h01, 8'h02, 8'h03};
    logic [DW-1:0] v8 [] = '{8'h80, 8'h81, 8'h82, 8'h83, 8'h84, 8'h85, 8'h86, 8'h87};
    logic [DW-1:0] v6 [] = '{8'h61, 8'h62, 8'h63, 8'h64};

    rst = 1'b1; fifo_clr = 1'b1; start = 1'b0; len = '0; abort = 1'b0;
    out_ready = 1'b1; wr_en = 1'b0; wr_data = '0;
    tick(); tick();
    rst = 1'b0; fifo_clr = 1'b0;
    mid();
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_rem", 32'(remaining), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rden", 32'(fifo_rden), 0);

    // 1: full-rate burst
    load(v4, 4);
    tick(); start = 1'b1; len = 4'd4;
    for (int k = 1; k <= 6; k++) begin
      tick(); start = 1'b0;
      mid();
      chk("t1_rden", 32'(fifo_rden), 32'(k >= 1 && k <= 4));
      chk("t1_valid", 32'(out_valid), 32'(k >= 2 && k <= 5));
      chk("t1_done", 32'(done), 32'(k == 6));
      chk("t1_busy", 32'(busy), 32'(k < 6));
    end
    chk("t1_empty", 32'(fifo_empty), 1);

    // 2: backpressure in cycles 3-5
    fifo_flush();
    load(v4, 4);
    tick(); start = 1'b1; len = 4'd4;
    for (int k = 1; k <= 10; k++) begin
      tick(); start = 1'b0;
      out_ready = !(k >= 3 && k <= 5);
      mid();
      if (k >= 3 && k <= 5) begin
        chk("t2_hold", 32'(out_data), 32'h22);
        chk("t2_rden", 32'(fifo_rden), 0);
      end
      chk("t2_done", 32'(done), 32'(k == 9));
    end
    out_ready = 1'b1;

    // 3: empty stall then late data
    fifo_flush();
    tick(); start = 1'b1; len = 4'd2;
    for (int k = 1; k <= 10; k++) begin
      tick(); start = 1'b0;
      mid();
      chk("t3_busy", 32'(busy), 1);
      chk("t3_rden", 32'(fifo_rden), 0);
      chk("t3_rem", 32'(remaining), 2);
    end
    tick(); wr_en = 1'b1; wr_data = 8'hA5; exp_q.push_back(8'hA5);
    tick(); wr_data = 8'h5A; exp_q.push_back(8'h5A);
    tick(); wr_en = 1'b0;
    dcnt = 0;
    for (int k = 0; k < 20; k++) begin
      mid(); if (done) dcnt++;
      tick();
    end
    chk("t3_done_cnt", 32'(dcnt), 1);
    chk("t3_sb", 32'(exp_q.size()), 0);

    // 4: zero length
    fifo_flush();
    load(v3, 0);
    tick(); start = 1'b1; len = 4'd0;
    tick(); start = 1'b0;
    mid(); chk("t4_done1", 32'(done), 1);
    tick(); mid(); chk("t4_done0", 32'(done), 0);
    tick(); tick(); mid();
    chk("t4_busy", 32'(busy), 0);
    chk("t4_pops", 32'(pop_cnt), 0);
    chk("t4_fcnt", 32'(fcnt), 3);

    // 5: saturated length, start while busy ignored
    fifo_flush();
    load(v8, 8);
    tick(); start = 1'b1; len = 4'd12;
    dcnt = 0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      start = (k == 3);
      len = (k == 3) ? 4'd3 : 4'd12;
      wr_en = (k == 3 || k == 4);
      wr_data = (k == 3) ? 8'hE1 : 8'hE2;
      mid();
      if (k == 1) chk("t5_rem_sat", 32'(remaining), 8);
      if (done) dcnt++;
    end
    wr_en = 1'b0;
    chk("t5_done_cnt", 32'(dcnt), 1);
    chk("t5_pops", 32'(pop_cnt), 8);
    chk("t5_fcnt", 32'(fcnt), 2);
    chk("t5_busy", 32'(busy), 0);

    // 6a: abort after two beats
    fifo_flush();
    load(v6, 2);
    tick(); start = 1'b1; len = 4'd4;
    tick(); start = 1'b0; mid();
    tick(); mid();
    tick(); abort = 1'b1; mid();
    chk("t6_abort_rden", 32'(fifo_rden), 0);
    tick(); abort = 1'b0; mid();
    chk("t6_valid", 32'(out_valid), 0);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_done", 32'(done), 0);
    chk("t6_rem", 32'(remaining), 0);
    chk("t6_fcnt", 32'(fcnt), 2);
    tick(); mid();
    chk("t6_done_late", 32'(done), 0);

    // 6b: reset mid-burst
    fifo_flush();
    load(v6, 0);
    tick(); start = 1'b1; len = 4'd4;
    tick(); start = 1'b0; mid();
    tick(); rst = 1'b1; mid();
    tick(); rst = 1'b0; mid();
    chk("t6r_valid", 32'(out_valid), 0);
    chk("t6r_data", 32'(out_data), 0);
    chk("t6r_done", 32'(done), 0);
    chk("t6r_rem", 32'(remaining), 0);
    chk("t6r_busy", 32'(busy), 0);
    chk("t6r_rden", 32'(fifo_rden), 0);

    chk("sb_drained", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
